slave_arbiter: RTL and testbench
================================

# slave_arbiter

Per-slave arbitration stage directly downstream of the per-master port handlers in the cross bar. It takes the request streams of all MASTER_NUM port handlers addressed to one slave and grants them round-robin. It drives the single slave-side request/ack channel. Read responses are returned in order to the master that issued them, using an in-order master-ID queue.

## Interface
- AWIDTH, 32, address width
- DWIDTH, 32, data width
- MASTER_NUM, 2, number of requesting masters (≥2)
- ORDER_DEPTH, 4, outstanding read capacity (power of two)

- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  reset, synchronous, active-low
- m_req  in  MASTER_NUM  per-master request, held until acked
- m_addr  in  MASTER_NUM*AWIDTH  per-master address, master i at [i*AWIDTH +: AWIDTH]
- m_cmd  in  MASTER_NUM  per-master command, 1 = read, 0 = write
- m_wdata  in  MASTER_NUM*DWIDTH  per-master write data
- m_ack  out  MASTER_NUM  per-master accept strobe
- m_resp  out  MASTER_NUM  per-master read-response strobe
- m_rdata  out  DWIDTH  read data, shared, valid with m_resp
- s_req  out  1  slave request
- s_addr  out  AWIDTH  slave address
- s_cmd  out  1  slave command
- s_wdata  out  DWIDTH  slave write data
- s_ack  in  1  slave accept
- s_resp  in  1  slave read-response strobe
- s_rdata  in  DWIDTH  slave read data
- err_unexp_resp  out  1  sticky: s_resp arrived with no outstanding read

## Operation
- FSM has two states.
  - IDLE: if any m_req is eligible, pick the winner round-robin, starting from the index after last_grant. Register grant_id and the winner's addr/cmd/wdata, then go to GRANT.
  - GRANT: s_req=1 and s_addr/s_cmd/s_wdata come from the registers. When s_ack=1, pulse m_ack[grant_id] combinationally in the same cycle, set last_grant←grant_id, and return to IDLE.
- A transfer completes on the cycle where s_req & s_ack. Masters keep m_req and payload stable until m_ack.
- Eligibility: a write is always eligible. A read is eligible only when the order queue is not full. If a read is ineligible, that master is skipped for that cycle and the next eligible master wins.
- Order queue: an accepted read (cmd=1) pushes grant_id. s_resp pops the head; m_resp[head]=1 and m_rdata=s_rdata in the same cycle (combinational pass-through).
- Push and pop in the same cycle: both occur and the count is unchanged. A push when full cannot happen because of the eligibility rule.
- s_resp with the queue empty: data is dropped, no m_resp is raised, and err_unexp_resp is set. It is cleared only by reset.
- Counts and pointers are log2(ORDER_DEPTH) bits and wrap modulo ORDER_DEPTH. The count has one extra bit.
- Reset values:
  - s_req=0, s_addr/s_cmd/s_wdata=0
  - m_ack=0, m_resp=0, m_rdata=0 (gated)
  - state=IDLE, last_grant=MASTER_NUM-1 (so master 0 has first priority)
  - queue empty, err_unexp_resp=0
- Reset mid-operation: the pending grant is abandoned and s_req drops on the next edge. Outstanding reads are forgotten; later slave responses to them set err_unexp_resp.

## Timing
- m_req rising in cycle 0 (IDLE) → s_req=1 in cycle 1.
- s_ack in cycle n → m_ack in cycle n. State is IDLE at n+1, and the next s_req is at n+2 at the earliest (one bubble per transfer).
- Read response latency through the block is 0 cycles (s_resp → m_resp in the same cycle).
- m_ack and m_resp are single-cycle strobes. Any number of cycles may pass between ack and response.

## Configuration
- SLAVE_ARB_STATS_EN defined: adds output grant_cnt (MASTER_NUM*16 bits) with one 16-bit counter per master. Each counter increments on that master's m_ack, saturates at 16'hFFFF, and resets to 0.
- Not defined: no counters and no grant_cnt port. All other behaviour is identical.

## Structure
- cross_bar_pkg holds:
  - CMD_READ=1'b1 and CMD_WRITE=1'b0
  - the arbiter state enum (ARB_IDLE, ARB_GRANT)
  - a function for the ID width, $clog2(MASTER_NUM)
- One sub-module, resp_order_fifo: a synchronous FIFO of master IDs with push/pop/full/empty/head outputs, parameterised by depth and width.

## Test plan
- Single read, then write, from master 0 only: m_req[0]=1, cmd=1, addr=0x10. Required: s_req in cycle 1; with s_ack in cycle 3, m_ack[0] in cycle 3. s_resp with rdata=0xCAFE gives m_resp[0]=1 and m_rdata=0xCAFE. The following write produces no m_resp.
- Both masters hold m_req continuously (writes): grants alternate 0,1,0,1 over four transfers, with exactly one bubble cycle between s_req pulses.
- Master 1 issues 4 reads (ORDER_DEPTH=4) with no responses while master 0 holds a read and master 1 holds a write. Required: master 0's read is not granted, master 1's write is granted. After one s_resp, master 0's read is granted next.
- Interleaved reads in order 0,1,1,0 with responses 0xA,0xB,0xC,0xD: m_resp strobes go to masters 0,1,1,0 respectively with matching data. Include a response pop in the same cycle as a read push.
- s_resp with an empty queue → no m_resp and err_unexp_resp=1. Then assert aresetn=0 for 1 cycle during GRANT: s_req=0 and err_unexp_resp=0 on the next edge.
- With SLAVE_ARB_STATS_EN: 3 grants to master 1 give grant_cnt[16 +: 16]=3. A counter forced to 16'hFFFF stays at 16'hFFFF after the next grant.

Source files
------------

// File: rtl/cross_bar_pkg.sv
// cross_bar_pkg: shared command encodings, arbiter state type and ID-width helper
package cross_bar_pkg;
  localparam logic CMD_READ  = 1'b1;
  localparam logic CMD_WRITE = 1'b0;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/resp_order_fifo.sv
// resp_order_fifo: synchronous FIFO holding the master ID of each outstanding read,
// popped in issue order when the slave returns data.
module resp_order_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty   = cnt_q == '0;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: rtl/slave_arbiter.sv
// slave_arbiter: round-robin arbitration of MASTER_NUM request streams onto one slave,
// with in-order read-response routing. SLAVE_ARB_STATS_EN adds per-master grant counters.
module slave_arbiter
  import cross_bar_pkg::*;
#(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int MASTER_NUM  = 2,
  parameter int ORDER_DEPTH = 4
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [MASTER_NUM-1:0]        m_req,
  input  logic [MASTER_NUM*AWIDTH-1:0] m_addr,
  input  logic [MASTER_NUM-1:0]        m_cmd,
  input  logic [MASTER_NUM*DWIDTH-1:0] m_wdata,
  output logic [MASTER_NUM-1:0]        m_ack,
  output logic [MASTER_NUM-1:0]        m_resp,
  output logic [DWIDTH-1:0]            m_rdata,
  output logic                         s_req,
  output logic [AWIDTH-1:0]            s_addr,
  output logic                         s_cmd,
  output logic [DWIDTH-1:0]            s_wdata,
  input  logic                         s_ack,
  input  logic                         s_resp,
  input  logic [DWIDTH-1:0]            s_rdata,
`ifdef SLAVE_ARB_STATS_EN
  output logic [MASTER_NUM*16-1:0]     grant_cnt,
`endif
  output logic                         err_unexp_resp
);
  localparam int IW = id_width(MASTER_NUM);

  arb_state_e        state_q, state_d;
  logic [IW-1:0]     grant_id_q, grant_id_d, last_grant_q, last_grant_d;
  logic [AWIDTH-1:0] addr_q, addr_d, sel_addr;
  logic              cmd_q, cmd_d, sel_cmd;
  logic [DWIDTH-1:0] wdata_q, wdata_d, sel_wdata;
  logic              err_q, err_d;
  logic [MASTER_NUM-1:0] elig;
  logic [IW-1:0]     win, q_head;
  logic              found, acked, push, pop, q_full, q_empty;

  // Reads are held back while the order queue cannot record another ID.
  always_comb begin
    for (int i = 0; i < MASTER_NUM; i++)
      elig[i] = m_req[i] && (m_cmd[i] == CMD_WRITE || !q_full);
  end

  // Lowest eligible index above last_grant wins; otherwise wrap to lowest overall.
  always_comb begin
    found = 1'b0;
    win   = last_grant_q;
    for (int i = MASTER_NUM - 1; i >= 0; i--)
      if (elig[i]) begin
        found = 1'b1;
        win   = IW'(i);
      end
    for (int i = MASTER_NUM - 1; i >= 0; i--)
      if (elig[i] && i > int'(last_grant_q)) win = IW'(i);
  end

  always_comb begin
    sel_addr  = '0;
    sel_cmd   = 1'b0;
    sel_wdata = '0;
    for (int i = 0; i < MASTER_NUM; i++)
      if (win == IW'(i)) begin
        sel_addr  = m_addr[i*AWIDTH +: AWIDTH];
        sel_cmd   = m_cmd[i];
        sel_wdata = m_wdata[i*DWIDTH +: DWIDTH];
      end
  end

  always_comb begin
    state_d      = state_q;
    grant_id_d   = grant_id_q;
    addr_d       = addr_q;
    cmd_d        = cmd_q;
    wdata_d      = wdata_q;
    last_grant_d = last_grant_q;
    acked        = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (found) begin
        state_d    = ARB_GRANT;
        grant_id_d = win;
        addr_d     = sel_addr;
        cmd_d      = sel_cmd;
        wdata_d    = sel_wdata;
      end
    end else if (s_ack) begin
      acked        = 1'b1;
      last_grant_d = grant_id_q;
      state_d      = ARB_IDLE;
    end
  end

  assign push  = acked && cmd_q == CMD_READ;
  assign pop   = s_resp && !q_empty;
  assign err_d = err_q || (s_resp && q_empty);

  always_comb begin
    for (int i = 0; i < MASTER_NUM; i++) begin
      m_ack[i]  = acked && grant_id_q == IW'(i);
      m_resp[i] = pop && q_head == IW'(i);
    end
  end

  assign m_rdata        = pop ? s_rdata : '0;
  assign s_req          = state_q == ARB_GRANT;
  assign s_addr         = addr_q;
  assign s_cmd          = cmd_q;
  assign s_wdata        = wdata_q;
  assign err_unexp_resp = err_q;

  resp_order_fifo #(
    .DEPTH(ORDER_DEPTH),
    .WIDTH(IW)
  ) u_order (
    .aclk   (aclk),
    .aresetn(aresetn),
    .push   (push),
    .din    (grant_id_q),
    .pop    (pop),
    .full   (q_full),
    .empty  (q_empty),
    .head   (q_head)
  );

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= ARB_IDLE;
      grant_id_q   <= '0;
      last_grant_q <= IW'(MASTER_NUM - 1);
      addr_q       <= '0;
      cmd_q        <= 1'b0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_id_q   <= grant_id_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      cmd_q        <= cmd_d;
      wdata_q      <= wdata_d;
      err_q        <= err_d;
    end
  end

`ifdef SLAVE_ARB_STATS_EN
  logic [MASTER_NUM-1:0][15:0] cnt_q, cnt_d;

  always_comb begin
    for (int i = 0; i < MASTER_NUM; i++)
      cnt_d[i] = (m_ack[i] && cnt_q[i] != 16'hFFFF) ? cnt_q[i] + 16'd1 : cnt_q[i];
  end

  assign grant_cnt = cnt_q;

  always_ff @(posedge aclk) begin
    if (!aresetn) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`endif
endmodule

// File: tb/tb_slave_arbiter.sv
// tb_slave_arbiter: scoreboard bench for slave_arbiter; read responses are queued at
// acceptance and checked against m_resp/m_rdata when the slave answers.
module tb_slave_arbiter;
  import cross_bar_pkg::*;
  localparam int AW = 32, DW = 32, MN = 2, OD = 4;

  logic aclk = 1'b0, aresetn = 1'b0;
  logic [MN-1:0] m_req = '0, m_cmd = '0, m_ack, m_resp;
  logic [MN*AW-1:0] m_addr = '0;
  logic [MN*DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata, s_wdata, s_rdata = '0;
  logic [AW-1:0] s_addr;
  logic s_req, s_cmd, s_ack = 1'b0, s_resp = 1'b0, err_unexp_resp;
`ifdef SLAVE_ARB_STATS_EN
  logic [MN*16-1:0] grant_cnt;
`endif

  typedef struct {int m; logic [DW-1:0] d;} rsp_t;
  rsp_t sb[$];
  int n_chk = 0, n_pass = 0;
  int w;

  slave_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .MASTER_NUM(MN), .ORDER_DEPTH(OD)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_resp(m_resp), .m_rdata(m_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_cmd(s_cmd), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata),
`ifdef SLAVE_ARB_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .err_unexp_resp(err_unexp_resp)
  );

  always #5 aclk = ~aclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [MN-1:0] oh(input int i);
    oh = '0;
    oh[i] = 1'b1;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic set_m(input int i, input logic req, input logic cmd, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd);
    m_req[i] = req;
    m_cmd[i] = cmd;
    m_addr[i*AW +: AW] = a;
    m_wdata[i*DW +: DW] = wd;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    m_req = '0;
    s_ack = 1'b0;
    s_resp = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
  endtask

  task automatic grant(input int m, input logic cmd, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                       input logic [DW-1:0] rd, input bit drop, input bit pop_too, output int waited);
    rsp_t e;
    waited = 0;
    while (!s_req && waited < 20) begin
      tick();
      waited++;
    end
    check("s_req_seen", s_req, 1);
    check("s_addr", s_addr, a);
    check("s_cmd", s_cmd, cmd);
    if (cmd == CMD_WRITE) check("s_wdata", s_wdata, wd);
    s_ack = 1'b1;
    if (pop_too) begin
      e = sb.pop_front();
      s_resp = 1'b1;
      s_rdata = e.d;
    end
    #1;
    check("m_ack", m_ack, oh(m));
    if (pop_too) begin
      check("m_resp_pp", m_resp, oh(e.m));
      check("m_rdata_pp", m_rdata, e.d);
    end
    if (cmd == CMD_READ) sb.push_back('{m, rd});
    tick();
    s_ack = 1'b0;
    s_resp = 1'b0;
    if (drop) m_req[m] = 1'b0;
    #1;
    check("bubble", s_req, 0);
    check("m_ack_strobe", m_ack, 0);
  endtask

  task automatic resp();
    rsp_t e;
    e = sb.pop_front();
    s_resp = 1'b1;
    s_rdata = e.d;
    #1;
    check("m_resp", m_resp, oh(e.m));
    check("m_rdata", m_rdata, e.d);
    tick();
    s_resp = 1'b0;
    s_rdata = '0;
    #1;
    check("m_resp_strobe", m_resp, 0);
  endtask

  initial begin
    tick();
    tick();
    check("rst_s_req", s_req, 0);
    check("rst_s_addr", s_addr, 0);
    check("rst_s_cmd", s_cmd, 0);
    check("rst_s_wdata", s_wdata, 0);
    check("rst_m_ack", m_ack, 0);
    check("rst_m_resp", m_resp, 0);
    check("rst_m_rdata", m_rdata, 0);
    check("rst_err", err_unexp_resp, 0);
    aresetn = 1'b1;

    // single read then write from master 0
    set_m(0, 1'b1, CMD_READ, 32'h10, 32'h0);
    #1;
    check("c0_s_req", s_req, 0);
    tick();
    check("c1_s_req", s_req, 1);
    tick();
    tick();
    grant(0, CMD_READ, 32'h10, 32'h0, 32'hCAFE, 1'b1, 1'b0, w);
    check("c3_no_wait", w, 0);
    tick();
    tick();
    resp();
    set_m(0, 1'b1, CMD_WRITE, 32'h20, 32'h55);
    grant(0, CMD_WRITE, 32'h20, 32'h55, 32'h0, 1'b1, 1'b0, w);
    for (int c = 0; c < 3; c++) begin
      check("wr_no_resp", m_resp, 0);
      tick();
    end

    // round robin with both masters writing continuously
    do_reset();
    for (int i = 0; i < MN; i++) set_m(i, 1'b1, CMD_WRITE, 32'h100 + i, 32'h200 + i);
    for (int k = 0; k < 4; k++) begin
      grant(k % 2, CMD_WRITE, 32'h100 + k % 2, 32'h200 + k % 2, 32'h0, k >= 2, 1'b0, w);
      if (k > 0) check("rr_bubble", w, 1);
    end

    // queue full blocks reads but not writes
    do_reset();
    set_m(1, 1'b1, CMD_READ, 32'h40, 32'h0);
    for (int k = 0; k < OD; k++) grant(1, CMD_READ, 32'h40, 32'h0, 32'h100 + k, k == OD - 1, 1'b0, w);
    set_m(0, 1'b1, CMD_READ, 32'h30, 32'h0);
    set_m(1, 1'b1, CMD_WRITE, 32'h44, 32'h77);
    grant(1, CMD_WRITE, 32'h44, 32'h77, 32'h0, 1'b1, 1'b0, w);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("full_block", s_req, 0);
    end
    resp();
    grant(0, CMD_READ, 32'h30, 32'h0, 32'h1FF, 1'b1, 1'b0, w);
    for (int k = 0; k < OD; k++) resp();

    // interleaved reads 0,1,1,0 with a pop coinciding with a push
    set_m(0, 1'b1, CMD_READ, 32'h50, 32'h0);
    grant(0, CMD_READ, 32'h50, 32'h0, 32'hA, 1'b1, 1'b0, w);
    set_m(1, 1'b1, CMD_READ, 32'h51, 32'h0);
    grant(1, CMD_READ, 32'h51, 32'h0, 32'hB, 1'b1, 1'b0, w);
    set_m(1, 1'b1, CMD_READ, 32'h52, 32'h0);
    grant(1, CMD_READ, 32'h52, 32'h0, 32'hC, 1'b1, 1'b1, w);
    set_m(0, 1'b1, CMD_READ, 32'h53, 32'h0);
    grant(0, CMD_READ, 32'h53, 32'h0, 32'hD, 1'b1, 1'b0, w);
    for (int k = 0; k < 3; k++) resp();

    // unexpected response, then reset during GRANT
    s_resp = 1'b1;
    s_rdata = 32'hDEAD;
    #1;
    check("unexp_m_resp", m_resp, 0);
    check("unexp_m_rdata", m_rdata, 0);
    tick();
    s_resp = 1'b0;
    #1;
    check("err_set", err_unexp_resp, 1);
    tick();
    check("err_sticky", err_unexp_resp, 1);
    set_m(0, 1'b1, CMD_WRITE, 32'h60, 32'h1);
    tick();
    check("grant_state", s_req, 1);
    aresetn = 1'b0;
    tick();
    check("rst_mid_s_req", s_req, 0);
    check("rst_mid_err", err_unexp_resp, 0);
    aresetn = 1'b1;
    m_req = '0;
    tick();

`ifdef SLAVE_ARB_STATS_EN
    do_reset();
    for (int k = 0; k < 3; k++) begin
      set_m(1, 1'b1, CMD_WRITE, 32'h70, 32'h2);
      grant(1, CMD_WRITE, 32'h70, 32'h2, 32'h0, 1'b1, 1'b0, w);
    end
    check("cnt_m1", grant_cnt[16 +: 16], 3);
    check("cnt_m0", grant_cnt[0 +: 16], 0);
    force dut.cnt_q[1] = 16'hFFFF;
    #1;
    release dut.cnt_q[1];
    set_m(1, 1'b1, CMD_WRITE, 32'h70, 32'h2);
    grant(1, CMD_WRITE, 32'h70, 32'h2, 32'h0, 1'b1, 1'b0, w);
    check("cnt_sat", grant_cnt[16 +: 16], 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
